// File: rtl/bus_oe_sequencer.sv
// bus_oe_sequencer: one-hot-low 74245 output enables with a break-before-make dead period.
// The idle counter and the dead countdown share one register; only one of them is live per state.
module bus_oe_sequencer #(
    parameter int NUM_SRC     = 4,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                       CLK,
    input  logic                       N_RST,
    input  logic [$clog2(NUM_SRC):0]   SEL,
    input  logic                       SEL_VALID,
    output logic [NUM_SRC-1:0]         N_OE,
    output logic                       BUS_READY,
    output logic [$clog2(NUM_SRC)-1:0] CUR_SRC,
    output logic                       ERR
);
    localparam int IW = $clog2(NUM_SRC);
    localparam logic [3:0] DC = 4'(DEAD_CYCLES);

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IW-1:0]        cur_q, cur_d;
    logic [NUM_SRC-1:0]   n_oe_q, n_oe_d;
    logic                 err_q, err_d;
    logic                 in_range, req;
    logic [IW-1:0]        sel_idx;
    logic [NUM_SRC-1:0]   grant_n;

    assign in_range = SEL < (IW+1)'(NUM_SRC);
    assign req      = SEL_VALID && in_range;
    assign sel_idx  = SEL[IW-1:0];
    assign grant_n  = ~(NUM_SRC'(1) << sel_idx);

    // An out-of-range request behaves exactly like a release, plus the sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        n_oe_d  = '1;
        err_d   = err_q | (SEL_VALID && !in_range);
        case (state_q)
            IDLE: begin
                cnt_d = (cnt_q == DC) ? cnt_q : cnt_q + 4'd1;
                if (req && cnt_q == DC) begin
                    state_d = DRIVE;
                    cur_d   = sel_idx;
                    n_oe_d  = grant_n;
                end else if (req) begin
                    state_d = DEAD;
                    cnt_d   = DC - cnt_q;
                end
            end
            DEAD: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = DC - cnt_q;
                end else if (cnt_q == 4'd1) begin
                    state_d = DRIVE;
                    cur_d   = sel_idx;
                    n_oe_d  = grant_n;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRIVE: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd1;
                end else if (sel_idx == cur_q) begin
                    n_oe_d = n_oe_q;
                end else begin
                    state_d = DEAD;
                    cnt_d   = DC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q <= IDLE;
            cnt_q   <= DC;
            cur_q   <= '0;
            n_oe_q  <= '1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            n_oe_q  <= n_oe_d;
            err_q   <= err_d;
        end
    end

    assign N_OE      = n_oe_q;
    assign CUR_SRC   = cur_q;
    assign ERR       = err_q;
    assign BUS_READY = (state_q == DRIVE) && SEL_VALID && (SEL == {1'b0, cur_q});
endmodule

// File: tb/tb_bus_oe_sequencer.sv
// tb_bus_oe_sequencer: directed checks on three instances (DEAD_CYCLES 1, 2, 3) plus a random
// invariant run with asynchronous reset pulses.
module tb_bus_oe_sequencer;
    logic       clk = 1'b0;
    logic       n_rst;
    logic [2:0] sel1, sel2, sel3;
    logic       v1, v2, v3;
    logic [3:0] noe1, noe2, noe3;
    logic       rdy1, rdy2, rdy3;
    logic [1:0] cur1, cur2, cur3;
    logic       err1, err2, err3;
    int         checks = 0;
    int         errors = 0;

    bus_oe_sequencer #(.NUM_SRC(4), .DEAD_CYCLES(1)) d1 (
        .CLK(clk), .N_RST(n_rst), .SEL(sel1), .SEL_VALID(v1),
        .N_OE(noe1), .BUS_READY(rdy1), .CUR_SRC(cur1), .ERR(err1));
    bus_oe_sequencer #(.NUM_SRC(4), .DEAD_CYCLES(2)) d2 (
        .CLK(clk), .N_RST(n_rst), .SEL(sel2), .SEL_VALID(v2),
        .N_OE(noe2), .BUS_READY(rdy2), .CUR_SRC(cur2), .ERR(err2));
    bus_oe_sequencer #(.NUM_SRC(4), .DEAD_CYCLES(3)) d3 (
        .CLK(clk), .N_RST(n_rst), .SEL(sel3), .SEL_VALID(v3),
        .N_OE(noe3), .BUS_READY(rdy3), .CUR_SRC(cur3), .ERR(err3));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        {sel1, sel2, sel3} = '0;
        {v1, v2, v3} = '0;
        #12;
        chk("rst_noe", noe1, 4'hF);
        chk("rst_rdy", rdy1, 0);
        chk("rst_cur", cur1, 0);
        chk("rst_err", err1, 0);
        n_rst = 1'b1;
        tick();
        // first grant after reset needs no dead period
        sel1 = 2; v1 = 1;
        tick();
        chk("grant_noe", noe1, 4'b1011);
        chk("grant_rdy", rdy1, 1);
        chk("grant_cur", cur1, 2);
        sel1 = 0;
        tick();
        chk("sw_dead_noe", noe1, 4'hF);
        chk("sw_dead_rdy", rdy1, 0);
        tick();
        chk("sw_new_noe", noe1, 4'b1110);
        chk("sw_new_rdy", rdy1, 1);
        tick();
        chk("hold_noe", noe1, 4'b1110);
        // DEAD_CYCLES=3: switch 1->3, retarget to 2 without restarting the countdown
        sel3 = 1; v3 = 1;
        tick();
        chk("d3_grant1", noe3, 4'b1101);
        sel3 = 3;
        tick();
        chk("d3_dead1", noe3, 4'hF);
        sel3 = 2;
        tick();
        chk("d3_dead2", noe3, 4'hF);
        tick();
        chk("d3_dead3", noe3, 4'hF);
        tick();
        chk("d3_retgt_noe", noe3, 4'b1011);
        chk("d3_retgt_cur", cur3, 2);
        chk("d3_retgt_rdy", rdy3, 1);
        // release mid-DEAD credits elapsed dead time: remaining 2 -> idle counter 1
        sel3 = 0;
        tick();
        chk("d3_cr_dead_a", noe3, 4'hF);
        tick();
        chk("d3_cr_dead_b", noe3, 4'hF);
        v3 = 0;
        tick();
        chk("d3_cr_idle", noe3, 4'hF);
        v3 = 1;
        tick();
        chk("d3_cr_dead_c", noe3, 4'hF);
        tick();
        chk("d3_cr_dead_d", noe3, 4'hF);
        tick();
        chk("d3_cr_drive", noe3, 4'b1110);
        // DEAD_CYCLES=2: one idle cycle then a short dead period
        sel2 = 1; v2 = 1;
        tick();
        chk("d2_grant1", noe2, 4'b1101);
        v2 = 0;
        tick();
        chk("d2_rel", noe2, 4'hF);
        chk("d2_rel_rdy", rdy2, 0);
        sel2 = 3; v2 = 1;
        tick();
        chk("d2_dead", noe2, 4'hF);
        tick();
        chk("d2_grant3", noe2, 4'b0111);
        chk("d2_grant3_rdy", rdy2, 1);
        // out-of-range request while driving 0
        sel1 = 5;
        tick();
        chk("oor_noe", noe1, 4'hF);
        chk("oor_err", err1, 1);
        chk("oor_rdy", rdy1, 0);
        sel1 = 1;
        tick();
        chk("post_oor_noe", noe1, 4'b1101);
        chk("post_oor_err", err1, 1);
        chk("post_oor_cur", cur1, 1);
        sel1 = 2;
        #1;
        chk("rdy_mismatch", rdy1, 0);
        chk("err_others", {err2, err3}, 0);
        // random traffic with asynchronous reset pulses
        for (int i = 0; i < 10000; i++) begin
            sel1 = 3'($urandom_range(0, 7)); v1 = 1'($urandom_range(0, 1));
            sel2 = 3'($urandom_range(0, 7)); v2 = 1'($urandom_range(0, 1));
            sel3 = 3'($urandom_range(0, 7)); v3 = 1'($urandom_range(0, 1));
            tick();
            chk("onehot_d1", ($countones(~noe1) <= 1), 1);
            chk("onehot_d2", ($countones(~noe2) <= 1), 1);
            chk("onehot_d3", ($countones(~noe3) <= 1), 1);
            if (i % 997 == 500) begin
                #2 n_rst = 1'b0;
                #1;
                chk("async_rst_noe", {noe1, noe2, noe3}, 12'hFFF);
                chk("async_rst_err", {err1, err2, err3}, 0);
                #2 n_rst = 1'b1;
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
